// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Brief    : Shared types, defaults and helpers for the register write arbiter
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;
  localparam int MAX_N     = 8;
  localparam int MAX_IW    = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // Index to one-hot over the largest supported requester count; callers
  // truncate to their own N.
  function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [MAX_IW-1:0] idx);
    logic [MAX_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotate-priority picker; search starts at i_ptr,
//            ascends and wraps at N-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  // First requesting index at or after the pointer, wrapping around
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_any && i_req[j]) begin
        o_any = 1'b1;
        o_idx = IW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin arbiter sharing one WIDTH-bit register among N
//            requesters, with per-requester lock for multi-beat bursts.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           i_req,
  input  logic [N-1:0]           i_lock,
  input  logic [N*WIDTH-1:0]     i_wdata,
  output logic [N-1:0]           o_gnt,
  output logic [WIDTH-1:0]       o_q,
  output logic                   o_q_valid,
  output logic [$clog2(N)-1:0]   o_owner
);

  localparam int IW = $clog2(N);

  arb_state_t       r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;
  logic [N-1:0]     r_gnt;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;

  logic             w_any;
  logic [IW-1:0]    w_pick_idx;
  logic             w_hold;
  logic [IW-1:0]    w_sel;
  logic [N-1:0]     w_sel_oh;
  logic [WIDTH-1:0] w_data_arr [N];

  generate
    for (genvar g = 0; g < N; g++) begin : g_unpack
      assign w_data_arr[g] = i_wdata[g*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_pick_idx)
  );

  // The locked owner keeps the grant only while it is still requesting
  always_comb begin
    w_hold   = (r_state == ST_OWNED) && i_req[r_owner];
    w_sel    = w_hold ? r_owner : w_pick_idx;
    w_sel_oh = N'(idx_to_onehot(MAX_IW'(w_sel)));
  end

  // FSM, pointer and registered outputs; reset overrides everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_gnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (w_hold || w_any) begin
      r_gnt     <= w_sel_oh;
      r_q       <= w_data_arr[w_sel];
      r_q_valid <= 1'b1;
      r_owner   <= w_sel;
      r_state   <= i_lock[w_sel] ? ST_OWNED : ST_IDLE;
      // A held burst does not move the pointer; a fresh pick advances past it
      if (!w_hold) begin
        r_ptr <= (w_pick_idx == IW'(N-1)) ? '0 : w_pick_idx + IW'(1);
      end
    end else begin
      r_gnt     <= '0;
      r_q_valid <= 1'b0;
      r_state   <= ST_IDLE;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_q       = r_q;
  assign o_q_valid = r_q_valid;
  assign o_owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Directed self-checking bench for reg_write_arbiter (N=4, WIDTH=8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;

  reg_write_arbiter #(.N(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req),
    .i_lock    (lock),
    .i_wdata   (wdata),
    .o_gnt     (gnt),
    .o_q       (q),
    .o_q_valid (q_valid),
    .o_owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; lock = '0;
    tick();
    rst = 1'b1;
  endtask

  // Leaves ptr at 2 by granting requester 1 once
  task automatic set_ptr2();
    req = 4'b0010; lock = '0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; lock = '0;
    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0 || owner !== 2'd0) begin
        errors++;
        $display("FAIL reset[%0d]: gnt=%b q=%h v=%b owner=%0d, want 0000 00 0 0", c, gnt, q, q_valid, owner);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001 || q !== 8'hA0 || q_valid !== 1'b1 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: gnt=%b q=%h v=%b owner=%0d, want 0001 a0 1 0", gnt, q, q_valid, owner);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] eg;
    logic [7:0] eq;
    do_reset();
    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1111; lock = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      eg = 4'b0001 << (c % 4);
      eq = 8'hA0 + 8'(c % 4);
      checks++;
      if (gnt !== eg || q !== eq || q_valid !== 1'b1 || owner !== 2'(c % 4)) begin
        errors++;
        $display("FAIL fairness[%0d]: gnt=%b q=%h v=%b owner=%0d, want %b %h 1 %0d", c, gnt, q, q_valid, owner, eg, eq, c % 4);
      end
    end
  endtask

  task automatic test_sparse();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
    do_reset();
    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1010; lock = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== exp_g[c] || q_valid !== 1'b1) begin
        errors++;
        $display("FAIL sparse[%0d]: gnt=%b v=%b, want %b 1", c, gnt, q_valid, exp_g[c]);
      end
    end
    req = 4'b0000;
    wdata = {8'h33, 8'h22, 8'h11, 8'h00};
    tick();
    checks++;
    if (gnt !== 4'b0000 || q !== 8'hA1 || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL sparse_idle: gnt=%b q=%h v=%b, want 0000 a1 0", gnt, q, q_valid);
    end
  endtask

  task automatic test_lock_burst();
    do_reset();
    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    set_ptr2();
    req = 4'b0101; lock = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) lock = 4'b0000;
      wdata[23:16] = 8'h10 + 8'(c);
      tick();
      checks++;
      if (gnt !== 4'b0100 || q !== 8'h10 + 8'(c) || q_valid !== 1'b1 || owner !== 2'd2) begin
        errors++;
        $display("FAIL lock_burst[%0d]: gnt=%b q=%h v=%b owner=%0d, want 0100 %h 1 2", c, gnt, q, q_valid, owner, 8'h10 + 8'(c));
      end
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || q !== 8'hA0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL lock_after: gnt=%b q=%h owner=%0d, want 0001 a0 0", gnt, q, owner);
    end
  endtask

  task automatic test_lock_broken();
    do_reset();
    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    set_ptr2();
    req = 4'b0100; lock = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL broken_own: gnt=%b owner=%0d, want 0100 2", gnt, owner);
    end
    req = 4'b0001; lock = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0001 || q !== 8'hA0 || q_valid !== 1'b1 || owner !== 2'd0) begin
      errors++;
      $display("FAIL broken_next: gnt=%b q=%h v=%b owner=%0d, want 0001 a0 1 0", gnt, q, q_valid, owner);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    set_ptr2();
    req = 4'b0101; lock = 4'b0100;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL midburst_reset: gnt=%b q=%h v=%b owner=%0d, want 0000 00 0 0", gnt, q, q_valid, owner);
    end
    rst = 1'b1; lock = '0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || q !== 8'hA0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL midburst_rearb: gnt=%b q=%h owner=%0d, want 0001 a0 0", gnt, q, owner);
    end
  endtask

  initial begin
    rst = 1'b0; req = '0; lock = '0; wdata = '0;
    test_reset();
    test_fairness();
    test_sparse();
    test_lock_burst();
    test_lock_broken();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares one WIDTH-bit synchronous-reset storage register among N requesters. Each cycle it selects at most one requester, latches that requester's data into the shared register, and returns a registered one-hot grant. A per-requester lock lets a winner keep ownership for multi-cycle bursts. It sits in front of the team's synchronous-reset flip-flop datapath and sequences which source drives it.

## Interface
- N, default 4: number of requesters (2..8)
- WIDTH, default 8: data width of the shared register
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- req  in  N  request, bit i from requester i
- lock  in  N  bit i: requester i asks to keep the grant next cycle
- wdata  in  N*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- gnt  out  N  registered one-hot grant (all-zero when no winner)
- q  out  WIDTH  shared register contents
- q_valid  out  1  high for exactly the cycles in which q was written on the preceding edge
- owner  out  $clog2(N)  index of the current/last winner

## Operation
- Reset (posedge with rst=0): gnt=0, q=0, q_valid=0, owner=0, ptr=0, state=IDLE. Reset wins over every other input, including mid-burst.
- Round-robin pointer ptr: search starts at ptr, ascends, wraps at N-1 to 0; the first index with req=1 wins.
- FSM states: IDLE (no owner held), OWNED (owner holds the lock).
- IDLE, any req: winner = rr pick; gnt<=onehot(winner), q<=wdata[winner], q_valid<=1, owner<=winner, ptr<=(winner+1) mod N; go to OWNED if lock[winner]=1, else stay IDLE.
- IDLE, no req: gnt<=0, q holds, q_valid<=0, ptr holds.
- OWNED, req[owner]=1: owner keeps grant regardless of other reqs; q<=wdata[owner], q_valid<=1, ptr unchanged; stay OWNED if lock[owner]=1, otherwise go to IDLE (this is the final burst beat).
- OWNED, req[owner]=0: lock broken; act exactly as IDLE in the same cycle (rr pick among the others, starting at ptr).
- lock on a non-winning requester is ignored.
- Never more than one gnt bit is set; q changes only on an edge where q_valid becomes 1.

## Timing
- Arbitration is combinational from req/lock/ptr/state; all outputs are registered. Latency is one cycle from req sampled to gnt/q/q_valid visible.
- Throughput is one write per cycle. Back-to-back grants to different requesters are allowed with no bubble.
- A requester sees gnt[i]=1 in the cycle after the edge on which its wdata was captured. It treats gnt as a write acknowledge and may change wdata immediately.
- Simultaneous req from all N with ptr=k: grants go k, k+1, …, wrapping, one per cycle, provided reqs are held.
- When rst is released (rst=1), the first grant can appear on the next edge.

## Structure
- Package reg_arb_pkg: state enum {IDLE, OWNED}, default N/WIDTH localparams, and a function converting an index to one-hot.
- One sub-module, rr_pick: combinational rotate-priority picker (inputs req, ptr; outputs any, idx). The top module holds the FSM, ptr and output registers.

## Test plan
- Reset: hold rst=0 for 3 edges with req=4'b1111 -> gnt=0, q=0, q_valid=0, owner=0 throughout; release -> first grant gnt=4'b0001, q=wdata[0].
- Fairness: req=4'b1111 held for 8 cycles, wdata[i]=8'hA0+i -> gnt sequence 0001,0010,0100,1000,0001,… and q sequence A0,A1,A2,A3,A0,…
- Sparse: req=4'b1010 after ptr=0 -> gnt 0010 then 1000 then 0010; q_valid stays 1. With req=0, q_valid=0 and q holds its last value.
- Lock burst: req=4'b0101, lock[2]=1 for 3 cycles with ptr=2 -> gnt=0100 for 4 cycles (3 locked plus the final beat), then 0001; ptr advances to 3 after the first grant only.
- Lock broken: requester 2 owns with lock=1 and drops req[2] -> the next edge grants requester 0 (req=0001) with no idle cycle.
- Reset mid-burst: rst=0 for one edge during a lock -> all outputs are zero and state is IDLE; after release the arbiter rearbitrates from ptr=0.
